// File: rtl/iob_cycle_sequencer.sv
// iob_cycle_sequencer
// Runs one 68000-style bus cycle on the slow I/O bus for every fast-side
// access decoded into the IOB domain, paced by an internal tick divider.
// Optional feature macro: IOB_WRITE_POST_EN (posted writes: IOReady is
// returned right after acceptance and the IOB cycle finishes in background).
module iob_cycle_sequencer #(
    parameter int CLKDIV    = 4,    // CLK cycles per IOB tick (2..16)
    parameter int VPA_TICKS = 10,   // ticks waited after VPA is seen (>= 1)
    parameter int TIMEOUT   = 255   // ticks in WAIT before a bus error
) (
    input  logic CLK,
    input  logic RES,
    input  logic ASActive,
    input  logic IOCS,
    input  logic IACS,
    input  logic nWE,
    input  logic nDTACKIOB,
    input  logic nVPAIOB,
    output logic nASIOB,
    output logic nDSIOB,
    output logic RnWIOB,
    output logic IOBusy,
    output logic IOReady,
    output logic IOBERR
);

    localparam int TW = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKDIV - 1);
    localparam logic [7:0]    TO_LIMIT  = 8'(TIMEOUT);
    localparam logic [7:0]    VPA_LOAD  = 8'(VPA_TICKS);

    // S_PEND holds an accepted request until the next tick starts ADDR
    typedef enum logic [2:0] {
        S_IDLE, S_PEND, S_ADDR, S_STRB, S_WAIT, S_VPAW, S_DATA, S_END
    } state_t;

    state_t          state_reg, state_next;
    logic [TW-1:0]   tick_cnt_reg, tick_cnt_next;
    logic [7:0]      to_cnt_reg, to_cnt_next;
    logic [7:0]      vpa_cnt_reg, vpa_cnt_next;
    logic            rnw_reg, rnw_next;
    logic            posted_reg, posted_next;
    logic            as_n_reg, as_n_next;
    logic            ds_n_reg, ds_n_next;
    logic            busy_reg, busy_next;
    logic            ready_reg, ready_next;
    logic            berr_reg, berr_next;
    logic            tick;
    logic            req;
    logic            post_req;
    logic            req_rnw;
    logic [7:0]      to_inc;
    logic [7:0]      vpa_dec;

    // IACK cycles are always reads; only plain writes may be posted
    assign req_rnw = IACS | nWE;
`ifdef IOB_WRITE_POST_EN
    assign post_req = ~req_rnw;
`else
    assign post_req = 1'b0;
`endif

    assign tick    = (tick_cnt_reg == TICK_LAST);
    assign req     = ASActive && IOCS && !busy_reg;
    assign to_inc  = to_cnt_reg + 8'd1;
    assign vpa_dec = vpa_cnt_reg - 8'd1;

    // Next-state, counters and registered-output values
    always_comb begin
        state_next    = state_reg;
        tick_cnt_next = tick ? '0 : tick_cnt_reg + 1'b1;
        to_cnt_next   = to_cnt_reg;
        vpa_cnt_next  = vpa_cnt_reg;
        rnw_next      = rnw_reg;
        posted_next   = posted_reg;
        ready_next    = 1'b0;
        berr_next     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (req) begin
                    rnw_next    = req_rnw;
                    posted_next = post_req;
                    ready_next  = post_req;
                    // a request landing on a tick starts ADDR immediately
                    state_next  = tick ? S_ADDR : S_PEND;
                end
            end
            S_PEND: if (tick) state_next = S_ADDR;
            S_ADDR: if (tick) state_next = S_STRB;
            S_STRB: begin
                if (tick) begin
                    state_next  = S_WAIT;
                    to_cnt_next = 8'd0;
                end
            end
            S_WAIT: begin
                if (tick) begin
                    if (!nDTACKIOB) begin
                        state_next = S_DATA;
                    end else if (!nVPAIOB) begin
                        state_next   = S_VPAW;
                        vpa_cnt_next = VPA_LOAD;
                    end else begin
                        to_cnt_next = to_inc;
                        if (to_inc == TO_LIMIT) begin
                            state_next = S_IDLE;
                            berr_next  = 1'b1;
                        end
                    end
                end
            end
            S_VPAW: begin
                if (tick) begin
                    vpa_cnt_next = vpa_dec;
                    if (vpa_dec == 8'd0) state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    state_next = S_END;
                    ready_next = !posted_reg;
                end
            end
            S_END: if (tick) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        // Strobes follow the state being entered so they stay registered
        as_n_next = !(state_next inside {S_STRB, S_WAIT, S_VPAW, S_DATA});
        ds_n_next = !((state_next inside {S_WAIT, S_VPAW, S_DATA}) ||
                      (state_next == S_STRB && rnw_next));
        busy_next = (state_next != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_reg    <= S_IDLE;
            tick_cnt_reg <= '0;
            to_cnt_reg   <= 8'd0;
            vpa_cnt_reg  <= 8'd0;
            rnw_reg      <= 1'b1;
            posted_reg   <= 1'b0;
            as_n_reg     <= 1'b1;
            ds_n_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            ready_reg    <= 1'b0;
            berr_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tick_cnt_reg <= tick_cnt_next;
            to_cnt_reg   <= to_cnt_next;
            vpa_cnt_reg  <= vpa_cnt_next;
            rnw_reg      <= rnw_next;
            posted_reg   <= posted_next;
            as_n_reg     <= as_n_next;
            ds_n_reg     <= ds_n_next;
            busy_reg     <= busy_next;
            ready_reg    <= ready_next;
            berr_reg     <= berr_next;
        end
    end

    assign nASIOB  = as_n_reg;
    assign nDSIOB  = ds_n_reg;
    assign RnWIOB  = rnw_reg;
    assign IOBusy  = busy_reg;
    assign IOReady = ready_reg;
    assign IOBERR  = berr_reg;

endmodule

// File: tb/tb_iob_cycle_sequencer.sv
// Directed testbench for iob_cycle_sequencer (CLKDIV=4, VPA_TICKS=10,
// TIMEOUT=255). Edge indices count CLK edges since the last reset edge;
// with CLKDIV=4 an IOB tick falls on every edge index divisible by 4.
module tb_iob_cycle_sequencer;

    logic CLK = 1'b0;
    logic RES;
    logic ASActive, IOCS, IACS, nWE, nDTACKIOB, nVPAIOB;
    logic nASIOB, nDSIOB, RnWIOB, IOBusy, IOReady, IOBERR;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int ecount = 0;
    int req_e, a_e, a2_e;
    int rdy_seen = 0, berr_seen = 0, both_seen = 0;
    int rdy_mark, berr_mark;

    iob_cycle_sequencer #(.CLKDIV(4), .VPA_TICKS(10), .TIMEOUT(255)) dut (
        .CLK(CLK), .RES(RES), .ASActive(ASActive), .IOCS(IOCS), .IACS(IACS),
        .nWE(nWE), .nDTACKIOB(nDTACKIOB), .nVPAIOB(nVPAIOB),
        .nASIOB(nASIOB), .nDSIOB(nDSIOB), .RnWIOB(RnWIOB),
        .IOBusy(IOBusy), .IOReady(IOReady), .IOBERR(IOBERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) ecount <= RES ? 0 : ecount + 1;

    always @(negedge CLK) begin
        if (IOReady) rdy_seen <= rdy_seen + 1;
        if (IOBERR) berr_seen <= berr_seen + 1;
        if (IOReady && IOBERR) both_seen <= both_seen + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s act=%0d exp=%0d (edge %0d)", tag, act, exp, ecount);
        end
    endtask

    task automatic wait_clk();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_to(input int e);
        while (ecount < e) wait_clk();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_as"},    nASIOB,  1'b1);
        check_val({tag, "_ds"},    nDSIOB,  1'b1);
        check_val({tag, "_rnw"},   RnWIOB,  1'b1);
        check_val({tag, "_busy"},  IOBusy,  1'b0);
        check_val({tag, "_ready"}, IOReady, 1'b0);
        check_val({tag, "_berr"},  IOBERR,  1'b0);
    endtask

    // One-CLK request; a_e is the edge where ADDR is entered (first tick
    // at or after the request edge)
    task automatic start(input logic we_n, input logic iacs);
        ASActive = 1'b1; IOCS = 1'b1; IACS = iacs; nWE = we_n;
        req_e = ecount + 1;
        a_e   = req_e + (4 - (req_e % 4)) % 4;
        wait_clk();
        ASActive = 1'b0; IOCS = 1'b0; IACS = 1'b0; nWE = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RES = 1'b1; ASActive = 1'b0; IOCS = 1'b0; IACS = 1'b0; nWE = 1'b1;
        nDTACKIOB = 1'b1; nVPAIOB = 1'b1;
        repeat (3) wait_clk();
        check_reset_outputs("rst");
        RES = 1'b0;

        // Minimum read, DTACK tied low
        nDTACKIOB = 1'b0;
        wait_clk();
        start(1'b1, 1'b0);
        wait_to(a_e + 3);  check_val("rd_as_pre", nASIOB, 1'b1);
        wait_to(a_e + 4);  check_val("rd_as", nASIOB, 1'b0);
        check_val("rd_ds", nDSIOB, 1'b0);
        check_val("rd_rnw", RnWIOB, 1'b1);
        wait_to(a_e + 15); check_val("rd_rdy_pre", IOReady, 1'b0);
        wait_to(a_e + 16); check_val("rd_rdy", IOReady, 1'b1);
        check_val("rd_rnw_end", RnWIOB, 1'b1);
        wait_to(a_e + 17); check_val("rd_rdy_post", IOReady, 1'b0);
        wait_to(a_e + 20); check_val("rd_idle", IOBusy, 1'b0);
        $display("txn read-min req@%0d ready@%0d lat=%0d", req_e, a_e + 16, a_e + 16 - req_e);

        // Write, DTACK first seen on the fourth tick in WAIT
        nDTACKIOB = 1'b1;
        repeat (2) wait_clk();
        start(1'b0, 1'b0);
`ifdef IOB_WRITE_POST_EN
        check_val("wr_post_rdy", IOReady, 1'b1);
`else
        check_val("wr_post_rdy", IOReady, 1'b0);
`endif
        wait_to(a_e + 4);  check_val("wr_as", nASIOB, 1'b0);
        check_val("wr_ds_late", nDSIOB, 1'b1);
        check_val("wr_rnw", RnWIOB, 1'b0);
        wait_to(a_e + 8);  check_val("wr_ds", nDSIOB, 1'b0);
        wait_to(a_e + 20); nDTACKIOB = 1'b0;
        wait_to(a_e + 27); check_val("wr_rdy_pre", IOReady, 1'b0);
        wait_to(a_e + 28);
`ifdef IOB_WRITE_POST_EN
        check_val("wr_rdy", IOReady, 1'b0);
`else
        check_val("wr_rdy", IOReady, 1'b1);
`endif
        check_val("wr_as_end", nASIOB, 1'b1);
        wait_to(a_e + 32); check_val("wr_idle", IOBusy, 1'b0);
        $display("txn write-dtack3 req@%0d end@%0d", req_e, a_e + 28);

        // VPA-terminated read
        nDTACKIOB = 1'b1; nVPAIOB = 1'b0;
        repeat (3) wait_clk();
        berr_mark = berr_seen;
        start(1'b1, 1'b0);
        wait_to(a_e + 55); check_val("vpa_rdy_pre", IOReady, 1'b0);
        check_val("vpa_as", nASIOB, 1'b0);
        wait_to(a_e + 56); check_val("vpa_rdy", IOReady, 1'b1);
        wait_to(a_e + 60); check_val("vpa_idle", IOBusy, 1'b0);
        check_val("vpa_noberr", berr_seen - berr_mark, 0);
        $display("txn read-vpa req@%0d ready@%0d", req_e, a_e + 56);
        nVPAIOB = 1'b1;

        // IACK with nWE low behaves as a read
        nDTACKIOB = 1'b0;
        start(1'b0, 1'b1);
        check_val("iack_rnw", RnWIOB, 1'b1);
        wait_to(a_e + 4);  check_val("iack_ds", nDSIOB, 1'b0);
        wait_to(a_e + 16); check_val("iack_rdy", IOReady, 1'b1);
        wait_to(a_e + 20);
        $display("txn iack req@%0d ready@%0d", req_e, a_e + 16);

        // No acknowledge: timeout after 255 ticks in WAIT
        nDTACKIOB = 1'b1;
        wait_clk();
        rdy_mark = rdy_seen;
        start(1'b1, 1'b0);
        wait_to(a_e + 1027); check_val("to_berr_pre", IOBERR, 1'b0);
        check_val("to_as_pre", nASIOB, 1'b0);
        wait_to(a_e + 1028); check_val("to_berr", IOBERR, 1'b1);
        check_val("to_as", nASIOB, 1'b1);
        check_val("to_ds", nDSIOB, 1'b1);
        wait_to(a_e + 1029); check_val("to_berr_post", IOBERR, 1'b0);
        wait_to(a_e + 1032); check_val("to_idle", IOBusy, 1'b0);
        check_val("to_noready", rdy_seen - rdy_mark, 0);
        $display("txn read-timeout req@%0d berr@%0d", req_e, a_e + 1028);

        // Reset while in WAIT, then a normal read
        start(1'b1, 1'b0);
        wait_to(a_e + 9);  check_val("rw_busy", IOBusy, 1'b1);
        check_val("rw_as", nASIOB, 1'b0);
        RES = 1'b1;
        wait_clk();
        check_reset_outputs("rw");
        RES = 1'b0;
        nDTACKIOB = 1'b0;
        start(1'b1, 1'b0);
        wait_to(a_e + 16); check_val("rw_rdy", IOReady, 1'b1);
        wait_to(a_e + 20);
        $display("txn reset-in-wait then read req@%0d ready@%0d", req_e, a_e + 16);

        // Write followed by an immediately pending read
        ASActive = 1'b1; IOCS = 1'b1; nWE = 1'b0;
        req_e = ecount + 1;
        a_e   = req_e + (4 - (req_e % 4)) % 4;
        wait_clk();
        nWE = 1'b1;
`ifdef IOB_WRITE_POST_EN
        check_val("wp_rdy_acc", IOReady, 1'b1);
`else
        check_val("wp_rdy_acc", IOReady, 1'b0);
`endif
        wait_to(a_e + 16);
`ifdef IOB_WRITE_POST_EN
        check_val("wp_rdy_end", IOReady, 1'b0);
`else
        check_val("wp_rdy_end", IOReady, 1'b1);
`endif
        wait_to(a_e + 20); check_val("wp_rnw_wr", RnWIOB, 1'b0);
        check_val("wp_idle", IOBusy, 1'b0);
        wait_to(a_e + 21); check_val("wp_rnw_rd", RnWIOB, 1'b1);
        check_val("wp_busy_rd", IOBusy, 1'b1);
        ASActive = 1'b0; IOCS = 1'b0;
        a2_e = a_e + 24;
        wait_to(a2_e + 4);  check_val("wp_rd_as", nASIOB, 1'b0);
        check_val("wp_rd_ds", nDSIOB, 1'b0);
        wait_to(a2_e + 16); check_val("wp_rd_rdy", IOReady, 1'b1);
        wait_to(a2_e + 20); check_val("wp_rd_idle", IOBusy, 1'b0);
        $display("txn write+read req@%0d read-ready@%0d", req_e, a2_e + 16);

        check_val("never_both", both_seen, 0);
        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
